// File: rtl/i3c_line_drv.sv
// i3c_line_drv: per-line I3C SCL/SDA pad sequencer with break-before-make, PP keeper and input filter.
// Latency: 1 cycle request->pad for direct moves; DeadCycles/KeepCycles extra for sequenced moves; 2+FiltCycles pad->line_o.
// Backpressure: none; requests are level targets re-evaluated every edge, so a one-cycle request is still followed.
//
// Ports (all vectors are NumLines wide, one bit per line):
//   clk_i, rst_i        clock, synchronous active-high reset
//   data_i, sel_od_pp_i requested level and mode (0 = open-drain, 1 = push-pull)
//   pad_in_i            raw asynchronous pad input
//   conflict_clr_i      clear for the sticky conflict flag
//   pad_oe_o, pad_out_o registered pad enable / value
//   line_o              synchronised, glitch-filtered line level
//   conflict_o          sticky: line read low while we were driving it high
module i3c_line_drv #(
  parameter int NumLines   = 2,
  parameter int DeadCycles = 1,
  parameter int KeepCycles = 2,
  parameter int FiltCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumLines-1:0] data_i,
  input  logic [NumLines-1:0] sel_od_pp_i,
  input  logic [NumLines-1:0] pad_in_i,
  input  logic [NumLines-1:0] conflict_clr_i,
  output logic [NumLines-1:0] pad_oe_o,
  output logic [NumLines-1:0] pad_out_o,
  output logic [NumLines-1:0] line_o,
  output logic [NumLines-1:0] conflict_o
);

  localparam int MaxCyc = (DeadCycles > KeepCycles) ? DeadCycles : KeepCycles;
  localparam int CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

  // Blank window: sync latency + filter latency + one cycle of margin, so the
  // line has had time to follow our own drive before a low read counts.
  localparam int BlankCycles = 2 + FiltCycles + 1;
  localparam int BlankW      = $clog2(BlankCycles + 1);

  localparam logic [CntW-1:0] DeadLoad = (DeadCycles > 0) ? CntW'(DeadCycles - 1) : '0;
  localparam logic [CntW-1:0] KeepLoad = (KeepCycles > 0) ? CntW'(KeepCycles - 1) : '0;

  typedef enum logic [2:0] {
    ST_Z    = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_DEAD = 3'd3,
    ST_KEEP = 3'd4
  } state_e;

  for (genvar g = 0; g < NumLines; g++) begin : g_line
    state_e          r_state;
    state_e          w_state_nxt;
    state_e          w_tgt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_oe;
    logic            r_out;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_line;
    logic [BlankW-1:0] r_bcnt;
    logic            r_conf;
    logic            w_drv_hi;
    logic            w_conf_set;

    // Requested pad state.
    always_comb begin
      w_tgt = ST_Z;
      if (sel_od_pp_i[g]) begin
        w_tgt = data_i[g] ? ST_HI : ST_LO;
      end else begin
        w_tgt = data_i[g] ? ST_LO : ST_Z;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_Z;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_out   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        // Pad controls decoded from the next state so they leave a flop.
        r_oe    <= (w_state_nxt == ST_LO) || (w_state_nxt == ST_HI) || (w_state_nxt == ST_KEEP);
        r_out   <= (w_state_nxt == ST_HI) || (w_state_nxt == ST_KEEP);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      unique case (r_state)
        ST_Z: begin
          w_state_nxt = w_tgt;
        end
        ST_LO: begin
          if (w_tgt == ST_Z) begin
            w_state_nxt = ST_Z;
          end else if (w_tgt == ST_HI) begin
            if (DeadCycles > 0) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = DeadLoad;
            end else begin
              w_state_nxt = ST_HI;
            end
          end
        end
        ST_HI: begin
          if (w_tgt == ST_LO) begin
            if (DeadCycles > 0) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = DeadLoad;
            end else begin
              w_state_nxt = ST_LO;
            end
          end else if (w_tgt == ST_Z) begin
            if (KeepCycles > 0) begin
              w_state_nxt = ST_KEEP;
              w_cnt_nxt   = KeepLoad;
            end else begin
              w_state_nxt = ST_Z;
            end
          end
        end
        ST_DEAD: begin
          // Releasing needs no dead time; otherwise finish the gap and go
          // straight to whatever is requested now.
          if (w_tgt == ST_Z) begin
            w_state_nxt = ST_Z;
          end else if (r_cnt == '0) begin
            w_state_nxt = w_tgt;
          end else begin
            w_cnt_nxt = r_cnt - CntW'(1);
          end
        end
        ST_KEEP: begin
          if (w_tgt == ST_HI) begin
            w_state_nxt = ST_HI;
          end else if (w_tgt == ST_LO) begin
            if (DeadCycles > 0) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = DeadLoad;
            end else begin
              w_state_nxt = ST_LO;
            end
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_Z;
          end else begin
            w_cnt_nxt = r_cnt - CntW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_Z;
        end
      endcase
    end

    // Two-flop synchroniser, idle-high.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= pad_in_i[g];
        r_sync2 <= r_sync1;
      end
    end

    if (FiltCycles == 0) begin : g_nofilt
      assign w_line = r_sync2;
    end else begin : g_filt
      localparam int FiltW = $clog2(FiltCycles + 1);
      logic [FiltW-1:0] r_fcnt;
      logic             r_line;

      // line_o only follows sync2 after FiltCycles consecutive mismatches.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_fcnt <= '0;
          r_line <= 1'b1;
        end else if (r_sync2 != r_line) begin
          if (r_fcnt == FiltW'(FiltCycles - 1)) begin
            r_line <= r_sync2;
            r_fcnt <= '0;
          end else begin
            r_fcnt <= r_fcnt + FiltW'(1);
          end
        end else begin
          r_fcnt <= '0;
        end
      end

      assign w_line = r_line;
    end

    assign w_drv_hi   = (r_state == ST_HI) || (r_state == ST_KEEP);
    assign w_conf_set = w_drv_hi && (r_bcnt == BlankW'(BlankCycles)) && !w_line;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_bcnt <= '0;
        r_conf <= 1'b0;
      end else begin
        if (!w_drv_hi) begin
          r_bcnt <= '0;
        end else if (r_bcnt != BlankW'(BlankCycles)) begin
          r_bcnt <= r_bcnt + BlankW'(1);
        end
        // A new detection beats a simultaneous clear.
        r_conf <= w_conf_set | (r_conf & ~conflict_clr_i[g]);
      end
    end

    assign pad_oe_o[g]   = r_oe;
    assign pad_out_o[g]  = r_out;
    assign line_o[g]     = w_line;
    assign conflict_o[g] = r_conf;
  end

endmodule

// File: tb/tb_i3c_line_drv.sv
// tb_i3c_line_drv: directed vectors against i3c_line_drv with default parameters
// (NumLines=2, DeadCycles=1, KeepCycles=2, FiltCycles=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_i3c_line_drv;

  logic       clk_i;
  logic       rst_i;
  logic [1:0] data_i;
  logic [1:0] sel_od_pp_i;
  logic [1:0] pad_in_i;
  logic [1:0] conflict_clr_i;
  logic [1:0] pad_oe_o;
  logic [1:0] pad_out_o;
  logic [1:0] line_o;
  logic [1:0] conflict_o;

  int n_vec = 0;
  int n_err = 0;

  i3c_line_drv #(
    .NumLines  (2),
    .DeadCycles(1),
    .KeepCycles(2),
    .FiltCycles(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .sel_od_pp_i   (sel_od_pp_i),
    .pad_in_i      (pad_in_i),
    .conflict_clr_i(conflict_clr_i),
    .pad_oe_o      (pad_oe_o),
    .pad_out_o     (pad_out_o),
    .line_o        (line_o),
    .conflict_o    (conflict_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_pad(input string tag, input logic [1:0] oe, input logic [1:0] out);
    chk({tag, ".oe"}, pad_oe_o, oe);
    chk({tag, ".out"}, pad_out_o, out);
  endtask

  initial begin
    rst_i          = 1'b1;
    data_i         = 2'b00;
    sel_od_pp_i    = 2'b00;
    pad_in_i       = 2'b11;
    conflict_clr_i = 2'b00;
    tick(2);

    // Reset state
    chk_pad("rst", 2'b00, 2'b00);
    chk("rst.line", line_o, 2'b11);
    chk("rst.conf", conflict_o, 2'b00);
    rst_i = 1'b0;

    // OD 1 on line 0 -> LO one cycle later, line 1 untouched
    data_i = 2'b01;
    tick();
    chk_pad("od1", 2'b01, 2'b00);
    data_i = 2'b00;
    tick();
    chk_pad("od0", 2'b00, 2'b00);

    // PP 1 then PP 0: HI, one dead cycle, LO
    sel_od_pp_i = 2'b01; data_i = 2'b01;
    tick();
    chk_pad("pp1", 2'b01, 2'b01);
    data_i = 2'b00;
    tick();
    chk_pad("hi2lo.dead", 2'b00, 2'b00);
    tick();
    chk_pad("hi2lo.lo", 2'b01, 2'b00);

    // LO -> HI also through dead time
    data_i = 2'b01;
    tick();
    chk_pad("lo2hi.dead", 2'b00, 2'b00);
    tick();
    chk_pad("lo2hi.hi", 2'b01, 2'b01);

    // HI -> Z: two keeper cycles, then release
    sel_od_pp_i = 2'b00; data_i = 2'b00;
    tick();
    chk_pad("keep1", 2'b01, 2'b01);
    tick();
    chk_pad("keep2", 2'b01, 2'b01);
    tick();
    chk_pad("keep.rel", 2'b00, 2'b00);

    // PP 1 during KEEP returns to HI with no gap
    sel_od_pp_i = 2'b01; data_i = 2'b01;
    tick();
    chk_pad("rehi.hi", 2'b01, 2'b01);
    sel_od_pp_i = 2'b00; data_i = 2'b00;
    tick();
    chk_pad("rehi.keep", 2'b01, 2'b01);
    sel_od_pp_i = 2'b01; data_i = 2'b01;
    tick();
    chk_pad("rehi.back", 2'b01, 2'b01);
    tick();
    chk_pad("rehi.hold", 2'b01, 2'b01);

    // PP 0 during KEEP goes through dead time
    sel_od_pp_i = 2'b00; data_i = 2'b00;
    tick();
    chk_pad("k2lo.keep", 2'b01, 2'b01);
    sel_od_pp_i = 2'b01; data_i = 2'b00;
    tick();
    chk_pad("k2lo.dead", 2'b00, 2'b00);
    tick();
    chk_pad("k2lo.lo", 2'b01, 2'b00);
    sel_od_pp_i = 2'b00;
    tick();
    chk_pad("lo2z", 2'b00, 2'b00);

    // One-cycle low glitch on line 1 is rejected
    pad_in_i = 2'b01;
    tick();
    pad_in_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("glitch.line", line_o, 2'b11);
    end

    // Five-cycle low pulse: line_o falls four edges after it starts
    pad_in_i = 2'b01;
    tick(3);
    chk("pulse.e3", line_o, 2'b11);
    tick();
    chk("pulse.e4", line_o, 2'b01);
    tick();
    pad_in_i = 2'b11;
    tick(5);
    chk("pulse.rise", line_o, 2'b11);

    // Conflict: drive PP high on line 0 while the pad reads low
    pad_in_i = 2'b10;
    tick(4);
    chk("conf.line", line_o, 2'b10);
    sel_od_pp_i = 2'b01; data_i = 2'b01;
    tick();
    chk_pad("conf.hi", 2'b01, 2'b01);
    tick(4);
    chk("conf.blank", conflict_o, 2'b00);
    tick(2);
    chk("conf.set", conflict_o, 2'b01);
    conflict_clr_i = 2'b01;
    tick();
    chk("conf.setwins", conflict_o, 2'b01);
    conflict_clr_i = 2'b00;
    sel_od_pp_i = 2'b00; data_i = 2'b00;
    tick(3);
    chk_pad("conf.rel", 2'b00, 2'b00);
    chk("conf.sticky", conflict_o, 2'b01);
    conflict_clr_i = 2'b01;
    tick();
    chk("conf.clr", conflict_o, 2'b00);
    conflict_clr_i = 2'b00;

    // Reset in the middle of DEAD
    pad_in_i = 2'b01;
    tick(4);
    chk("pre.line", line_o, 2'b01);
    sel_od_pp_i = 2'b01; data_i = 2'b01;
    tick();
    chk_pad("pre.hi", 2'b01, 2'b01);
    data_i = 2'b00;
    tick();
    chk_pad("pre.dead", 2'b00, 2'b00);
    rst_i = 1'b1;
    tick();
    chk_pad("midrst", 2'b00, 2'b00);
    chk("midrst.line", line_o, 2'b11);
    chk("midrst.conf", conflict_o, 2'b00);
    rst_i = 1'b0;
    tick();
    chk_pad("postrst.lo", 2'b01, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i3c_line_drv.md
# i3c_line_drv

Parametrised per-line controller for the I3C SCL/SDA pad drivers, generalising the single-line OD/PP buffer model to `NumLines` independent lines. Each line turns a combined open-drain/push-pull drive request into registered pad output-enable and output-value signals. The sequencing includes break-before-make dead time and a push-pull-high keeper before release. The block also synchronises and glitch-filters the pad input and flags drive conflicts. It sits between the bus controller FSMs and the pad ring.

## Interface
Parameters:
- `NumLines`, 2, number of independent bus lines (index 0 = SCL, 1 = SDA by convention).
- `DeadCycles`, 1, hi-Z cycles inserted between driving high and driving low (0 = none).
- `KeepCycles`, 2, cycles a PP-high line keeps driving high before release to hi-Z (0 = none).
- `FiltCycles`, 2, consecutive stable synchronised samples required to update `line_o` (0 = no filter).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i` input 1 system clock; all state updates on the rising edge.
- `rst_i` input 1 synchronous active-high reset.
- `data_i` input NumLines requested data per line.
- `sel_od_pp_i` input NumLines mode per line: 0 = open-drain, 1 = push-pull.
- `pad_in_i` input NumLines raw pad input, asynchronous.
- `conflict_clr_i` input NumLines clear for the sticky conflict flag.
- `pad_oe_o` output NumLines pad output enable, registered.
- `pad_out_o` output NumLines pad output value, valid when `pad_oe_o`=1, registered.
- `line_o` output NumLines synchronised, filtered line level.
- `conflict_o` output NumLines sticky flag: the line was driven high while it read low.

## Operation
- Target per line, decoded combinationally:
  - OD with data 0 → Z.
  - OD with data 1 → LO.
  - PP with data 1 → HI.
  - PP with data 0 → LO.
- Per-line FSM states and registered outputs (oe/out):
  - Z: 0/0.
  - LO: 1/0.
  - HI: 1/1.
  - DEAD: 0/0.
  - KEEP: 1/1.
- Transitions from Z, LO and HI:
  - Z→LO and Z→HI: direct.
  - LO→Z: direct.
  - LO→HI: via DEAD.
  - HI→LO: via DEAD.
  - HI→Z: via KEEP.
  - DeadCycles=0 or KeepCycles=0 makes the corresponding transition direct.
- DEAD: the counter loads DeadCycles−1 on entry.
  - Target Z during DEAD → Z immediately.
  - Otherwise, at count 0, enter the current target (LO or HI) with no further dead time.
- KEEP: the counter loads KeepCycles−1 on entry.
  - Target HI → HI immediately.
  - Target LO → DEAD.
  - Target Z at count 0 → Z.
- Counter width: $clog2(max(DeadCycles, KeepCycles)+1), minimum 1.
- Input path per line: 2-flop synchroniser (reset 1) feeds sync2, followed by the filter counter.
  - When sync2 ≠ `line_o`, the counter increments.
  - At the edge where the counter equals FiltCycles−1 and the mismatch persists, `line_o` takes sync2 and the counter returns to 0.
  - Any cycle with sync2 = `line_o` clears the counter.
  - FiltCycles=0: `line_o` = sync2.
- Conflict detection:
  - A blank counter starts on entry to HI or KEEP from any other state. It holds at saturation while the state stays in {HI, KEEP}.
  - After 2+FiltCycles+1 cycles in {HI, KEEP}, `line_o`=0 sets `conflict_o`.
  - The blank counter clears in all other states.
  - `conflict_clr_i` clears the flag; set wins over a simultaneous clear.
- Lines are fully independent; no shared state.

## Timing
- Reset values:
  - `pad_oe_o`=0, `pad_out_o`=0.
  - `line_o`=1 (idle bus high).
  - `conflict_o`=0.
  - All FSMs in Z, all counters 0.
  - Reset mid-sequence (DEAD or KEEP) aborts to Z on the next edge.
- Request→pad latency: 1 cycle for direct transitions.
- HI→LO: DeadCycles cycles of oe=0, then LO. First low output appears DeadCycles+1 cycles after the request.
- HI→Z: oe=1/out=1 for KeepCycles cycles after the request edge, then Z.
- A request held for a single cycle is honoured: the FSM follows the target that was current at each edge.
- Pad→`line_o` latency: 2+FiltCycles edges for a stable change. Pulses shorter than FiltCycles cycles at sync2 are rejected.

## Test plan
- Reset, then OD data 1 on line 0 → next cycle `pad_oe_o`[0]=1, `pad_out_o`[0]=0; line 1 remains oe=0.
- PP 1 then PP 0, DeadCycles=1 → oe=1/out=1, then one cycle oe=0, then oe=1/out=0.
- PP 1 then OD 0, KeepCycles=2 → two cycles oe=1/out=1, then oe=0. A PP 1 request during KEEP returns to HI with no gap.
- `pad_in_i` low pulse of 1 cycle, FiltCycles=2 → `line_o` stays 1. A 5-cycle low pulse → `line_o`=0 four edges after the pulse starts.
- PP 1 with `pad_in_i` held 0 → `conflict_o` set after the blank period and stays set. `conflict_clr_i` with the line released (Z) → clears.
- Assert `rst_i` during DEAD → all outputs return to reset values on the next edge.
